// File: rtl/out_channel_pkg.sv
// Shared types and constants for the out_channel block: word type, channel
// state encoding and the expected output sequence used by the optional checker.
package out_channel_pkg;

  localparam int MEM_W = 12;
  localparam int N_EXP = 3;

  typedef logic [MEM_W-1:0] word_t;

  typedef enum logic [1:0] {
    ACCEPT,
    DRAIN,
    DONE
  } state_t;

  localparam word_t EXPECTED [N_EXP] = '{word_t'(11), word_t'(22), word_t'(33)};

endpackage

// File: rtl/out_channel_ram.sv
// Simple dual-port word store: synchronous write, asynchronous read.
// Contents are never reset; occupancy tracking lives in the caller.
module out_channel_ram #(
  parameter int Width = 12,
  parameter int Depth = 64
) (
  input  logic                     clock,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/out_channel.sv
// out_channel: buffers words from the core's `out` instruction in a circular
// store and drains them in order over valid/ready. Tracks program completion
// (ACCEPT -> DRAIN -> DONE) and raises `finished` once the store is empty.
// Build option OUT_CHANNEL_CHECK_EN compiles in a checker that compares drained
// words with EXPECTED and drives `success`; without it `success` is 0.
module out_channel
  import out_channel_pkg::*;
#(
  parameter int MemoryElementWidth = MEM_W,
  parameter int NOut               = 64,
  parameter int NExpected          = N_EXP
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [MemoryElementWidth-1:0] in_data,
  output logic                          in_ready,
  input  logic                          finish,
  output logic                          out_valid,
  output logic [MemoryElementWidth-1:0] out_data,
  input  logic                          out_ready,
  output logic [$clog2(NOut+1)-1:0]     count,
  output logic                          overflow,
  output logic                          finished,
  output logic                          success
);

  localparam int PW = $clog2(NOut);
  localparam int CW = $clog2(NOut+1);

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, empty, push, pop;

  assign full  = (count_q == CW'(NOut));
  assign empty = (count_q == '0);
  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;

  out_channel_ram #(
    .Width (MemoryElementWidth),
    .Depth (NOut)
  ) u_ram (
    .clock   (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

  // Pointer, occupancy and overflow next-state; pointers wrap by compare so
  // NOut need not be a power of two.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid && full && state_q == ACCEPT);
    if (push) wr_ptr_d = (wr_ptr_q == PW'(NOut-1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(NOut-1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Channel state next-state: finish closes the input; DONE once drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT:  if (finish) state_d = (empty && !push) ? DONE : DRAIN;
      DRAIN:   if (count_d == '0) state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  // Handshake and status outputs from registered state and occupancy.
  always_comb begin
    in_ready  = !full && (state_q == ACCEPT);
    out_valid = !empty && (state_q != DONE);
    finished  = (state_q == DONE);
  end

  // State, pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ACCEPT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef OUT_CHANNEL_CHECK_EN
  localparam int IW = $clog2(NExpected+1);

  logic [IW-1:0] pop_idx_q, pop_idx_d;
  logic          mismatch_q, mismatch_d;
  logic          success_q, success_d;

  // Compare each drained word with the expected sequence; extra words are a
  // mismatch. The verdict is latched on the edge that enters DONE, so it uses
  // the next-state values to include a pop on that same edge.
  always_comb begin
    pop_idx_d  = pop_idx_q;
    mismatch_d = mismatch_q;
    success_d  = success_q;
    if (pop) begin
      if (pop_idx_q >= IW'(NExpected)) begin
        mismatch_d = 1'b1;
      end else begin
        if (word_t'(out_data) != EXPECTED[pop_idx_q]) mismatch_d = 1'b1;
        pop_idx_d = pop_idx_q + 1'b1;
      end
    end
    if (state_q != DONE && state_d == DONE)
      success_d = !mismatch_d && (pop_idx_d == IW'(NExpected)) && !overflow_d;
  end

  // Checker registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pop_idx_q  <= '0;
      mismatch_q <= 1'b0;
      success_q  <= 1'b0;
    end else begin
      pop_idx_q  <= pop_idx_d;
      mismatch_q <= mismatch_d;
      success_q  <= success_d;
    end
  end

  assign success = success_q;
`else
  assign success = 1'b0;
`endif

endmodule

// File: tb/tb_out_channel.sv
// Bench for out_channel (NOut=4) with a queue-based reference model.
module tb_out_channel;

  localparam int NOUT = 4;
  localparam int W    = 12;
`ifdef OUT_CHANNEL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic         clock = 1'b0, reset = 1'b0;
  logic         in_valid = 1'b0, finish = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, overflow, finished, success;
  logic [W-1:0] out_data;
  logic [$clog2(NOUT+1)-1:0] count;

  out_channel #(.MemoryElementWidth(W), .NOut(NOUT), .NExpected(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .finish(finish), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .count(count),
    .overflow(overflow), .finished(finished), .success(success)
  );

  always #5 clock = ~clock;

  int tests_run = 0, tests_failed = 0;

  // Reference model: the buffer is a queue, plus flags for "program ended",
  // "done", sticky overflow and the verdict.
  int q[$];
  int popped[$];
  bit m_ended, m_done, m_ovf, m_success;

  function automatic bit e_in_ready();
    return !m_ended && q.size() < NOUT;
  endfunction

  function automatic bit e_out_valid();
    return !m_done && q.size() > 0;
  endfunction

  function automatic void model_reset();
    q.delete(); popped.delete();
    m_ended = 0; m_done = 0; m_ovf = 0; m_success = 0;
  endfunction

  function automatic void enter_done();
    bit ok;
    m_done = 1;
    ok = (popped.size() == 3) && !m_ovf;
    if (ok) ok = (popped[0] == 11) && (popped[1] == 22) && (popped[2] == 33);
    m_success = CHECK && ok;
  endfunction

  function automatic void model_step(bit iv, int id, bit ordy, bit fin);
    int n0 = q.size();
    bit was_ended = m_ended;
    bit do_push = iv && !m_ended && n0 < NOUT;
    bit do_pop  = !m_done && n0 > 0 && ordy;
    if (iv && !m_ended && n0 == NOUT) m_ovf = 1;
    if (do_pop) popped.push_back(q.pop_front());
    if (do_push) q.push_back(id);
    if (!was_ended && fin) begin
      m_ended = 1;
      if (n0 == 0 && !do_push) enter_done();
    end else if (was_ended && !m_done && q.size() == 0) begin
      enter_done();
    end
  endfunction

  task automatic do_reset();
    reset = 1; in_valid = 0; finish = 0; out_ready = 0; in_data = '0;
    @(posedge clock); #1;
    reset = 0;
    model_reset();
  endtask

  // One clock cycle with the given inputs; returns at edge+1.
  task automatic drive(bit iv, int id, bit ordy, bit fin);
    in_valid = iv; in_data = W'(id); out_ready = ordy; finish = fin;
    @(posedge clock);
    model_step(iv, id, ordy, fin);
    #1;
    finish = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (count !== 0)     begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count); end
    tests_run++; if (overflow !== 0)  begin tests_failed++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    tests_run++; if (finished !== 0)  begin tests_failed++; $display("FAIL reset_finished got %0b exp 0", finished); end
    tests_run++; if (success !== 0)   begin tests_failed++; $display("FAIL reset_success got %0b exp 0", success); end
    tests_run++; if (out_valid !== 0) begin tests_failed++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    tests_run++; if (in_ready !== 1)  begin tests_failed++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_flow();
    int exp_w[3] = '{11, 22, 33};
    int peak = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, exp_w[i], 1, 0);
      tests_run++; if (out_valid !== 1) begin tests_failed++; $display("FAIL flow_valid[%0d] got %0b exp 1", i, out_valid); end
      tests_run++; if (out_data !== W'(exp_w[i])) begin tests_failed++; $display("FAIL flow_data[%0d] got %0d exp %0d", i, out_data, exp_w[i]); end
      if (int'(count) > peak) peak = int'(count);
    end
    drive(0, 0, 1, 0);
    tests_run++; if (out_valid !== 0) begin tests_failed++; $display("FAIL flow_drained_valid got %0b exp 0", out_valid); end
    tests_run++; if (peak != 1) begin tests_failed++; $display("FAIL flow_peak_count got %0d exp 1", peak); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1, i, 0, 0);
    tests_run++; if (in_ready !== 0) begin tests_failed++; $display("FAIL full_in_ready got %0b exp 0", in_ready); end
    tests_run++; if (count !== 4)    begin tests_failed++; $display("FAIL full_count got %0d exp 4", count); end
    tests_run++; if (overflow !== 0) begin tests_failed++; $display("FAIL full_no_ovf got %0b exp 0", overflow); end
    drive(1, 5, 0, 0);
    tests_run++; if (overflow !== 1) begin tests_failed++; $display("FAIL ovf_set got %0b exp 1", overflow); end
    tests_run++; if (count !== 4)    begin tests_failed++; $display("FAIL ovf_count got %0d exp 4", count); end
    for (int i = 1; i <= 4; i++) begin
      tests_run++; if (out_data !== W'(i)) begin tests_failed++; $display("FAIL ovf_drain[%0d] got %0d exp %0d", i, out_data, i); end
      drive(0, 0, 1, 0);
    end
    tests_run++; if (count !== 0)    begin tests_failed++; $display("FAIL ovf_drain_count got %0d exp 0", count); end
    tests_run++; if (overflow !== 1) begin tests_failed++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
  endtask

  task automatic test_wrap();
    int nxt = 0;
    int got[$];
    bit iv, ordy;
    do_reset();
    for (int cyc = 0; cyc < 80 && got.size() < 10; cyc++) begin
      iv   = (nxt < 10) && e_in_ready();
      ordy = cyc[0];
      if (out_valid && ordy) got.push_back(int'(out_data));
      drive(iv, nxt, ordy, 0);
      if (iv) nxt++;
      tests_run++; if (count !== q.size() || count > NOUT) begin tests_failed++; $display("FAIL wrap_count cyc %0d got %0d exp %0d", cyc, count, q.size()); end
    end
    tests_run++; if (got.size() != 10) begin tests_failed++; $display("FAIL wrap_timeout got %0d words exp 10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      tests_run++; if (got[i] != i) begin tests_failed++; $display("FAIL wrap_order[%0d] got %0d exp %0d", i, got[i], i); end
    end
    tests_run++; if (overflow !== 0) begin tests_failed++; $display("FAIL wrap_overflow got %0b exp 0", overflow); end
  endtask

  task automatic test_finish();
    do_reset();
    drive(1, 7, 0, 0);
    drive(1, 8, 0, 0);
    drive(0, 0, 0, 1);
    tests_run++; if (in_ready !== 0) begin tests_failed++; $display("FAIL fin_in_ready got %0b exp 0", in_ready); end
    tests_run++; if (finished !== 0) begin tests_failed++; $display("FAIL fin_early got %0b exp 0", finished); end
    tests_run++; if (count !== 2)    begin tests_failed++; $display("FAIL fin_count got %0d exp 2", count); end
    drive(0, 0, 1, 0);
    tests_run++; if (finished !== 0) begin tests_failed++; $display("FAIL fin_one_left got %0b exp 0", finished); end
    drive(0, 0, 1, 0);
    tests_run++; if (finished !== 1) begin tests_failed++; $display("FAIL fin_done got %0b exp 1", finished); end
    tests_run++; if (out_valid !== 0) begin tests_failed++; $display("FAIL fin_valid got %0b exp 0", out_valid); end
    // Inputs and finish are ignored once done.
    drive(1, 9, 1, 1);
    tests_run++; if (count !== 0 || overflow !== 0) begin tests_failed++; $display("FAIL done_ignore count %0d ovf %0b exp 0 0", count, overflow); end
    tests_run++; if (finished !== 1 || in_ready !== 0) begin tests_failed++; $display("FAIL done_hold fin %0b rdy %0b exp 1 0", finished, in_ready); end
    tests_run++; if (success !== 0) begin tests_failed++; $display("FAIL done_success got %0b exp 0", success); end
    // Finish with an empty buffer.
    do_reset();
    drive(0, 0, 0, 1);
    tests_run++; if (finished !== 1) begin tests_failed++; $display("FAIL fin_empty got %0b exp 1", finished); end
    // A push on the finish cycle is accepted and then drained.
    do_reset();
    drive(1, 5, 0, 1);
    tests_run++; if (count !== 1 || finished !== 0) begin tests_failed++; $display("FAIL fin_push count %0d fin %0b exp 1 0", count, finished); end
    tests_run++; if (out_data !== W'(5)) begin tests_failed++; $display("FAIL fin_push_data got %0d exp 5", out_data); end
    drive(0, 0, 1, 0);
    tests_run++; if (finished !== 1) begin tests_failed++; $display("FAIL fin_push_done got %0b exp 1", finished); end
  endtask

  task automatic test_checker();
    int seqs[3][4] = '{'{11, 22, 33, 0}, '{11, 22, 34, 0}, '{11, 22, 33, 44}};
    int lens[3] = '{3, 3, 4};
    bit exp_s;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      for (int i = 0; i < lens[k]; i++) drive(1, seqs[k][i], 1, 0);
      drive(0, 0, 1, 1);
      for (int t = 0; t < 10 && !finished; t++) drive(0, 0, 1, 0);
      exp_s = CHECK && (k == 0);
      tests_run++; if (finished !== 1) begin tests_failed++; $display("FAIL chk_finish[%0d] timeout got %0b exp 1", k, finished); end
      tests_run++; if (success !== exp_s) begin tests_failed++; $display("FAIL chk_success[%0d] got %0b exp %0b", k, success, exp_s); end
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    for (int i = 1; i <= 5; i++) drive(1, i, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);
    tests_run++; if (count !== 3 || in_ready !== 0) begin tests_failed++; $display("FAIL rd_pre count %0d rdy %0b exp 3 0", count, in_ready); end
    #2 reset = 1;
    #1;
    tests_run++; if (count !== 0)     begin tests_failed++; $display("FAIL rd_count got %0d exp 0", count); end
    tests_run++; if (out_valid !== 0) begin tests_failed++; $display("FAIL rd_valid got %0b exp 0", out_valid); end
    tests_run++; if (finished !== 0)  begin tests_failed++; $display("FAIL rd_finished got %0b exp 0", finished); end
    tests_run++; if (overflow !== 0)  begin tests_failed++; $display("FAIL rd_overflow got %0b exp 0", overflow); end
    tests_run++; if (in_ready !== 1)  begin tests_failed++; $display("FAIL rd_in_ready got %0b exp 1", in_ready); end
    @(posedge clock); #1;
    reset = 0;
    model_reset();
    drive(1, 42, 0, 0);
    tests_run++; if (count !== 1 || out_data !== W'(42)) begin tests_failed++; $display("FAIL rd_accept count %0d data %0d exp 1 42", count, out_data); end
  endtask

  task automatic test_random();
    int done_cycles = 0;
    bit iv, ordy, fin;
    int d;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      tests_run++; if (in_ready !== e_in_ready()) begin tests_failed++; $display("FAIL rnd_in_ready cyc %0d got %0b exp %0b", cyc, in_ready, e_in_ready()); end
      tests_run++; if (out_valid !== e_out_valid()) begin tests_failed++; $display("FAIL rnd_out_valid cyc %0d got %0b exp %0b", cyc, out_valid, e_out_valid()); end
      if (e_out_valid()) begin
        tests_run++; if (out_data !== W'(q[0])) begin tests_failed++; $display("FAIL rnd_out_data cyc %0d got %0d exp %0d", cyc, out_data, q[0]); end
      end
      tests_run++; if (count !== q.size()) begin tests_failed++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, count, q.size()); end
      tests_run++; if (overflow !== m_ovf) begin tests_failed++; $display("FAIL rnd_overflow cyc %0d got %0b exp %0b", cyc, overflow, m_ovf); end
      tests_run++; if (finished !== m_done) begin tests_failed++; $display("FAIL rnd_finished cyc %0d got %0b exp %0b", cyc, finished, m_done); end
      tests_run++; if (success !== m_success) begin tests_failed++; $display("FAIL rnd_success cyc %0d got %0b exp %0b", cyc, success, m_success); end
      if (m_done) done_cycles++;
      if (done_cycles > 3) begin
        done_cycles = 0;
        do_reset();
      end else begin
        iv   = ($urandom % 3) != 0;
        d    = int'($urandom_range(0, 4095));
        ordy = ($urandom % 2) != 0;
        fin  = ($urandom % 40) == 0;
        drive(iv, d, ordy, fin);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flow();
    test_full_overflow();
    test_wrap();
    test_finish();
    test_checker();
    test_reset_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
